// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serial transmitter, LSB first.
// Accepts one byte per tx_start level sample in idle and frames it as
// start(0) + 8 data bits + stop(1). A one-cycle ST_DONE gap follows each
// frame so upstream can present the next byte after seeing tx_active fall.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk_50mhz,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_serial
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_active;
  logic             r_done;
  logic             r_serial;
  logic             w_bit_end;

  // Last clock of the current bit period.
  assign w_bit_end = (r_baud == CNT_W'(CLKS_PER_BIT - 1));

  assign tx_active = r_active;
  assign tx_done   = r_done;
  assign tx_serial = r_serial;

  // Frame sequencer; every output is a register updated here.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_serial <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_serial <= 1'b1;
          r_done   <= 1'b0;
          if (tx_start) begin
            r_shift  <= tx_data;
            r_active <= 1'b1;
            r_serial <= 1'b0;
            r_bit    <= '0;
            r_baud   <= '0;
            r_state  <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_serial <= r_shift[0];
            r_state  <= ST_DATA;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_serial <= 1'b1;
              r_state  <= ST_STOP;
            end else begin
              // Next bit is what will sit in shift[0] after this shift.
              r_serial <= r_shift[1];
              r_bit    <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_baud   <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_baud <= r_baud + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // tx_start deliberately ignored here: upstream gets one cycle
          // after tx_active falls to swap tx_data.
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
          r_done   <= 1'b0;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: directed + randomized bench for uart_tx_byte at
// CLKS_PER_BIT=4. A behavioural UART receiver decodes the line
// independently of the DUT's internal structure.
module tb_uart_tx_byte;
  localparam int CPB     = 4;
  localparam int SPACING = 10 * CPB + 2;

  logic       clk_50mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       tx_start  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_active;
  logic       tx_done;
  logic       tx_serial;

  int checks   = 0;
  int failures = 0;

  always #5 clk_50mhz = ~clk_50mhz;

  uart_tx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .tx_serial(tx_serial)
  );

  int cyc = 0;
  always @(posedge clk_50mhz) cyc++;

  // Receiver model: hunts for a falling line, samples mid-bit, and logs
  // each decoded byte with the cycle its start bit began.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         done_cnt  = 0;
  int         done_bad  = 0;
  int         frame_bad = 0;
  logic       prev_act  = 1'b0;
  logic       prev_done = 1'b0;
  bit         dec_on    = 1'b0;
  int         dec_k     = 0;
  int         dec_t     = 0;
  int         dec_bi    = 0;
  logic [7:0] dec_b     = 8'h00;

  always @(negedge clk_50mhz) begin
    if (reset) begin
      dec_on    = 1'b0;
      prev_act  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (prev_done || !(prev_act === 1'b1 && tx_active === 1'b0)) done_bad++;
      end
      if (!dec_on) begin
        if (tx_serial === 1'b0) begin
          dec_on = 1'b1;
          dec_k  = 0;
          dec_t  = cyc;
        end
      end else begin
        dec_k++;
        if (dec_k % CPB == CPB / 2) begin
          dec_bi = dec_k / CPB;
          if (dec_bi == 0) begin
            if (tx_serial !== 1'b0) frame_bad++;
          end else if (dec_bi <= 8) begin
            dec_b[dec_bi-1] = tx_serial;
          end else begin
            if (tx_serial !== 1'b1) frame_bad++;
            rx_q.push_back(dec_b);
            rx_t.push_back(dec_t);
            dec_on = 1'b0;
          end
        end
      end
      prev_act  = tx_active;
      prev_done = tx_done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_act(input logic v, input string tag);
    int n = 0;
    @(negedge clk_50mhz);
    while (tx_active !== v && n < 200) begin
      @(negedge clk_50mhz);
      n++;
    end
    chk({tag, " wait_active"}, {31'd0, tx_active}, {31'd0, v});
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk_50mhz);
    while (tx_done !== 1'b1 && n < 200) begin
      @(negedge clk_50mhz);
      n++;
    end
    chk({tag, " wait_done"}, {31'd0, tx_done}, 32'd1);
  endtask

  // One-cycle start pulse; returns just after the accepting edge.
  task automatic send_pulse(input logic [7:0] d);
    @(posedge clk_50mhz); #1;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk_50mhz); #1;
    tx_start = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
  endtask

  // Held-start burst: swap tx_data in the cycle tx_active is seen low,
  // drop tx_start on that cycle after the last byte.
  task automatic run_burst(input logic [7:0] bs[4], input string tag);
    clear_rx();
    @(posedge clk_50mhz); #1;
    tx_data  = bs[0];
    tx_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_act(1'b1, tag);
      wait_act(1'b0, tag);
      if (k < 3) tx_data = bs[k+1];
      else       tx_start = 1'b0;
    end
    repeat (60) @(negedge clk_50mhz);
    chk({tag, " count"}, rx_q.size(), 4);
    for (int k = 0; k < 4; k++) chk({tag, " byte"}, {24'd0, rx_q[k]}, {24'd0, bs[k]});
    for (int k = 0; k < 3; k++) chk({tag, " spacing"}, rx_t[k+1] - rx_t[k], SPACING);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bs[4];
    logic [7:0] exp_bits[$];
    logic [7:0] d;
    logic [9:0] frame;
    int         d0;

    // Reset state
    repeat (3) @(posedge clk_50mhz);
    #1 reset = 1'b0;
    @(negedge clk_50mhz);
    chk("rst serial", {31'd0, tx_serial}, 32'd1);
    chk("rst active", {31'd0, tx_active}, 32'd0);
    chk("rst done",   {31'd0, tx_done},   32'd0);

    // Single byte 0xA5: full per-cycle waveform from the frame definition
    clear_rx();
    d0 = done_cnt;
    d  = 8'hA5;
    frame = {1'b1, d, 1'b0};
    send_pulse(d);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk_50mhz);
      chk($sformatf("a5 line c%0d", i), {31'd0, tx_serial}, {31'd0, frame[i / CPB]});
      chk($sformatf("a5 active c%0d", i), {31'd0, tx_active}, 32'd1);
    end
    @(negedge clk_50mhz);
    chk("a5 active fall", {31'd0, tx_active}, 32'd0);
    chk("a5 done pulse",  {31'd0, tx_done},   32'd1);
    @(negedge clk_50mhz);
    chk("a5 done clear",  {31'd0, tx_done},   32'd0);
    chk("a5 line idle",   {31'd0, tx_serial}, 32'd1);
    repeat (5) @(negedge clk_50mhz);
    chk("a5 rx byte", {24'd0, rx_q[0]}, 32'hA5);
    chk("a5 done count", done_cnt - d0, 1);

    // Random single bytes against the receiver
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_bits.push_back(d);
      send_pulse(d);
      wait_done("rand");
    end
    repeat (5) @(negedge clk_50mhz);
    chk("rand count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("rand byte", {24'd0, rx_q[i]}, {24'd0, exp_bits[i]});

    // Four-byte burst, fixed then random
    bs = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_burst(bs, "burst");
    for (int k = 0; k < 4; k++) bs[k] = 8'($urandom_range(0, 255));
    run_burst(bs, "rburst");

    // Data change mid-frame
    clear_rx();
    send_pulse(8'h3C);
    repeat (9) @(posedge clk_50mhz);
    #1 tx_data = 8'hFF;
    wait_done("midchg");
    repeat (3) @(negedge clk_50mhz);
    chk("midchg count", rx_q.size(), 1);
    chk("midchg byte", {24'd0, rx_q[0]}, 32'h3C);

    // Start held after last byte: back-to-back retransmission
    clear_rx();
    @(posedge clk_50mhz); #1;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    for (int n = 0; n < 400 && rx_q.size() < 3; n++) @(negedge clk_50mhz);
    chk("held reached3", {31'd0, rx_q.size() >= 3}, 32'd1);
    tx_start = 1'b0;
    repeat (60) @(negedge clk_50mhz);
    chk("held count", rx_q.size(), 3);
    for (int k = 0; k < 3; k++) chk("held byte", {24'd0, rx_q[k]}, 32'h81);
    for (int k = 0; k < 2; k++) chk("held spacing", rx_t[k+1] - rx_t[k], SPACING);

    // Reset mid-frame at cycle 17 of a 0x00 frame
    clear_rx();
    d0 = done_cnt;
    send_pulse(8'h00);
    repeat (15) @(posedge clk_50mhz);
    #1 reset = 1'b1;
    @(posedge clk_50mhz);
    #1 reset = 1'b0;
    @(negedge clk_50mhz);
    chk("rstmid serial", {31'd0, tx_serial}, 32'd1);
    chk("rstmid active", {31'd0, tx_active}, 32'd0);
    chk("rstmid done",   {31'd0, tx_done},   32'd0);
    repeat (2) @(posedge clk_50mhz);
    d = 8'($urandom_range(0, 255));
    send_pulse(d);
    wait_done("rstmid");
    repeat (3) @(negedge clk_50mhz);
    chk("rstmid count", rx_q.size(), 1);
    chk("rstmid byte", {24'd0, rx_q[0]}, {24'd0, d});
    chk("rstmid dones", done_cnt - d0, 1);

    // tx_start high only during the ST_DONE cycle is ignored
    clear_rx();
    d0 = done_cnt;
    d = 8'($urandom_range(0, 255));
    send_pulse(d);
    wait_done("stdone");
    tx_start = 1'b1;
    @(posedge clk_50mhz); #1;
    tx_start = 1'b0;
    repeat (50) @(negedge clk_50mhz);
    chk("stdone count", rx_q.size(), 1);
    chk("stdone byte", {24'd0, rx_q[0]}, {24'd0, d});
    chk("stdone dones", done_cnt - d0, 1);
    chk("stdone active", {31'd0, tx_active}, 32'd0);

    // Global integrity
    chk("frame errors", frame_bad, 0);
    chk("done pulse shape", done_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_byte.md
Name: uart_tx_byte

Overview:
- Serial byte transmitter on the `clk_50mhz` domain; the sink of the `tx_start` / `tx_data` / `tx_active` handshake used by the host-report blocks (offset, sample and status senders).
- Latches one byte per start request and shifts it out 8N1, LSB first, on `tx_serial`.
- `tx_serial` drives the USB-UART bridge pin.
- Only one requester is granted the `tx_*` bus at a time; muxing is upstream.

Parameters:
- CLKS_PER_BIT, 434, clocks per bit; 50 MHz / 115200 baud, truncated. Legal range 2..65535. Benches use 4.
- CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk_50mhz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_start  in  1  level start request; sampled only in ST_IDLE.
- tx_data  in  8  byte to send; captured on the accepting edge only.
- tx_active  out  1  high exactly while a frame is on the line.
- tx_done  out  1  one-cycle pulse after the stop bit completes.
- tx_serial  out  1  UART line; idles high.

Behaviour:
- Reset (sync, active-high):
  - `tx_serial`=1, `tx_active`=0, `tx_done`=0, state=ST_IDLE, counters cleared.
  - Reset mid-frame aborts the frame immediately. The line returns high on the next edge and no `tx_done` is issued.
  - Reset has priority over everything else.
- States: ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_DONE. All outputs are registered.
- ST_IDLE:
  - `tx_serial`=1.
  - On edge E with `tx_start`=1: shift reg <= `tx_data`, `tx_active` <= 1, `tx_serial` <= 0, bit counter <= 0, baud counter <= 0, go to ST_START.
  - `tx_active` is therefore visible the cycle after `tx_start` is sampled. Upstream relies on this one-cycle latency.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-idle line state.
  - The bit ends on the edge where counter==CLKS_PER_BIT-1; the counter then wraps to 0.
- ST_START: holds the line low for CLKS_PER_BIT cycles. At bit end: `tx_serial` <= shift[0], go to ST_DATA.
- ST_DATA:
  - At each bit end: shift right and increment the bit counter.
  - After the 8th bit (bit counter==7 at bit end): `tx_serial` <= 1, go to ST_STOP.
- ST_STOP: line high for CLKS_PER_BIT cycles. At bit end: `tx_active` <= 0, `tx_done` <= 1, go to ST_DONE.
- ST_DONE:
  - Mandatory one-cycle gap. `tx_start` is ignored.
  - Next edge: `tx_done` <= 0, go to ST_IDLE.
  - Purpose: gives upstream one cycle after seeing `tx_active`=0 to present the next `tx_data` before it is sampled.
- Timing:
  - `tx_active` is high for exactly 10*CLKS_PER_BIT cycles per frame.
  - Minimum accept-to-accept spacing is 10*CLKS_PER_BIT+2 cycles.
- Data hold: `tx_data` and `tx_start` changes during a frame have no effect on the frame in progress.
- Level semantics: if `tx_start` is still high when ST_IDLE is re-entered, the current `tx_data` is sent as a new frame.
  - Upstream contract: after its final byte, drop `tx_start` no later than the cycle it observes `tx_active`=0.
  - Otherwise that byte is retransmitted. This is intended, not an error.
- No parity, no break generation, no FIFO. Back-pressure is solely via `tx_active`.

Test Plan (CLKS_PER_BIT=4):
- Single byte:
  - Stimulus: `tx_data`=0xA5, `tx_start` pulsed 1 cycle.
  - Response: `tx_serial` per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - `tx_active` high 40 cycles starting the cycle after the sampling edge.
  - `tx_done` is a single pulse coincident with `tx_active` falling. The line then stays 1.
- Four-byte burst, `tx_start` held high:
  - Driver waits for `tx_active` low, then changes `tx_data` in that cycle, sending 0x12,0x34,0x56,0x78.
  - Response: decoded bytes are exactly 0x12,0x34,0x56,0x78 with no duplicates.
  - Exactly 1 idle cycle between `tx_active` low and the next start bit.
  - After the 4th byte, `tx_start` is dropped on the `tx_active` fall cycle. Response: no 5th frame.
- Data change mid-frame:
  - Stimulus: start with 0x3C, change `tx_data` to 0xFF at cycle 10.
  - Response: received byte is 0x3C.
- Start held after last byte:
  - Stimulus: send 0x81 and keep `tx_start`=1 indefinitely.
  - Response: 0x81 is retransmitted back-to-back with 42-cycle spacing.
- Reset mid-frame:
  - Stimulus: assert `reset` for 1 cycle at cycle 17 of a 0x00 frame.
  - Response: `tx_serial`=1 and `tx_active`=0 from the next edge, no `tx_done`.
  - A new start 3 cycles later transmits cleanly.
- `tx_start` during ST_DONE:
  - Stimulus: `tx_start` high only in the ST_DONE cycle.
  - Response: ignored, no frame.
